aes256_round_seq: RTL and testbench
===================================

AES256_ROUND_SEQ -- requirements
Module: aes256_round_seq

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 resetn  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  plaintext block offered.
REQ-004 in_ready  output  1  block accepted when in_valid & in_ready.
REQ-005 in_block  input  16x8  plaintext, byte 15 most significant.
REQ-006 rk  input  16x8  round key from key schedule, indexed by rk_idx, valid same cycle.
REQ-007 rk_idx  output  4  round-key index requested, 0..14.
REQ-008 init_block  output  16x8  registered in_block XOR rk(0), datapath initial state.
REQ-009 load  output  1  one-cycle pulse: datapath takes init_block as current state.
REQ-010 wr_en  output  1  state-register write enable.
REQ-011 round  output  4  round number 0..13; 13 selects the final round (no MixColumns).
REQ-012 state_q  input  16x8  state-register output.
REQ-013 out_valid  output  1  ciphertext available.
REQ-014 out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-015 out_block  output  16x8  ciphertext, registered.

Function
REQ-016 FSM states SHALL be IDLE, ROUND, FINAL and DONE.
REQ-017 IDLE: in_ready=1; rk_idx=0; on in_valid -> init_block<=in_block^rk, load<=1 next cycle, round<=0, go ROUND.
REQ-018 ROUND: in_ready=0, wr_en=1 every cycle, rk_idx=round+1, round increments by 1 per cycle.
REQ-019 ROUND with round==13: round holds at 13 (no wrap to 14/0), next state FINAL.
REQ-020 FINAL: wr_en=0, rk_idx=14, out_block<=state_q^rk, out_valid<=1, go DONE.
REQ-021 DONE: out_valid=1 and out_block stable until out_ready; on handshake out_valid<=0, go IDLE.
REQ-022 Latency: input handshake at edge T -> out_valid high from edge T+16; exactly 14 wr_en cycles per block.
REQ-023 in_valid in ROUND/FINAL/DONE SHALL be ignored; in_ready=1 only in IDLE (no overlap of blocks).
REQ-024 out_ready high before out_valid SHALL have no effect; out_ready high on the first DONE cycle -> IDLE next cycle.
REQ-025 All XORs SHALL be bytewise 128-bit, no width extension; round/rk_idx SHALL never exceed 13/14.
REQ-026 in_ready, wr_en, rk_idx SHALL be combinational decodes of state/round; all others registered.

Reset
REQ-027 resetn low: state=IDLE, round=0, load=0, out_valid=0, init_block=0, out_block=0, asynchronously.
REQ-028 Reset mid-block SHALL discard the block; first post-reset cycle in_ready=1, wr_en=0.

Structure
REQ-029 Package aes256_pkg SHALL hold NB=16, LAST_ROUND=13, KEY_ROUNDS=14, the 16x8 block typedef and the FSM state enum.
REQ-030 One sub-module aes_add_rkey16 (16-byte XOR) SHALL be instantiated twice (initial and final key addition).
REQ-031 Round datapath, key schedule and state register SHALL remain external.

Verification
REQ-032 Reset, then idle 5 cycles -> in_ready=1, wr_en=0, out_valid=0, out_block=0.
REQ-033 FIPS-197 C.3: key 000102..1f, pt 00112233445566778899aabbccddeeff with reference datapath -> out_block 8ea2b7ca516745bfeafc49904b496089 at T+16.
REQ-034 Same block: wr_en high exactly 14 cycles, round sequence 0..13, rk_idx 0,1..14, load single pulse at T+1.
REQ-035 out_ready held low 10 cycles after out_valid -> out_valid and out_block unchanged; in_valid pulses in that window ignored.
REQ-036 resetn asserted when round=7 -> outputs reset immediately; new block afterwards yields correct ciphertext at T+16.
REQ-037 out_ready tied high, in_valid tied high -> back-to-back blocks accepted every 17 cycles.

Source files
------------

// File: rtl/aes256_pkg.sv
// Shared definitions for the AES-256 round sequencer.
//   NB          bytes per block
//   LAST_ROUND  final sequenced round (no MixColumns in the external datapath)
//   KEY_ROUNDS  index of the last round key
//   block_t     16x8 block, byte 15 most significant
//   state_t     sequencer FSM states
package aes256_pkg;

  localparam int unsigned NB         = 16;
  localparam int unsigned LAST_ROUND = 13;
  localparam int unsigned KEY_ROUNDS = 14;

  typedef logic [NB-1:0][7:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

endpackage

// File: rtl/aes_add_rkey16.sv
// AddRoundKey: bytewise XOR of a 16-byte block with a 16-byte round key.
//   a  block operand
//   b  round key
//   y  a ^ b, same width as the operands
module aes_add_rkey16
  import aes256_pkg::*;
(
  input  block_t a,
  input  block_t b,
  output block_t y
);

  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      y[i] = a[i] ^ b[i];
    end
  end

endmodule

// File: rtl/aes256_round_seq.sv
// AES-256 round sequencer. Accepts one plaintext block, performs the initial
// key addition, steps an external round datapath through 14 rounds while
// requesting round keys from an external key schedule, then adds the last
// round key and presents the ciphertext until the consumer takes it.
//   clk, resetn           clock, asynchronous active-low reset
//   in_valid/in_ready     plaintext handshake, in_block plaintext
//   rk, rk_idx            round key returned for the requested index (0..14)
//   init_block, load      initial state for the datapath and its load pulse
//   wr_en, round          datapath write enable and round number (13 = final)
//   state_q               datapath state-register output
//   out_valid/out_ready   ciphertext handshake, out_block ciphertext
module aes256_round_seq
  import aes256_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  block_t     in_block,
  input  block_t     rk,
  output logic [3:0] rk_idx,
  output block_t     init_block,
  output logic       load,
  output logic       wr_en,
  output logic [3:0] round,
  input  block_t     state_q,
  output logic       out_valid,
  input  logic       out_ready,
  output block_t     out_block
);

  state_t     fsm, fsm_next;
  logic [3:0] round_next;
  logic       load_next;
  logic       out_valid_next;
  logic       init_en;
  logic       out_en;
  block_t     init_xor;
  block_t     final_xor;

  aes_add_rkey16 u_init_key (
    .a (in_block),
    .b (rk),
    .y (init_xor)
  );

  aes_add_rkey16 u_final_key (
    .a (state_q),
    .b (rk),
    .y (final_xor)
  );

  // load and wr_en overlap on the first ROUND cycle: the datapath runs
  // round 0 on init_block instead of state_q, so the 14 rounds occupy
  // exactly 14 cycles.
  always_comb begin
    fsm_next       = fsm;
    round_next     = round;
    load_next      = 1'b0;
    out_valid_next = out_valid;
    init_en        = 1'b0;
    out_en         = 1'b0;
    case (fsm)
      IDLE: begin
        if (in_valid) begin
          init_en    = 1'b1;
          load_next  = 1'b1;
          round_next = '0;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        if (round == 4'(LAST_ROUND)) begin
          fsm_next = FINAL;
        end else begin
          round_next = round + 4'd1;
        end
      end
      FINAL: begin
        out_en         = 1'b1;
        out_valid_next = 1'b1;
        fsm_next       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          fsm_next       = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (fsm == IDLE);
    wr_en    = (fsm == ROUND);
    case (fsm)
      ROUND:   rk_idx = round + 4'd1;
      FINAL:   rk_idx = 4'(KEY_ROUNDS);
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm        <= IDLE;
      round      <= '0;
      load       <= 1'b0;
      out_valid  <= 1'b0;
      init_block <= '0;
      out_block  <= '0;
    end else begin
      fsm       <= fsm_next;
      round     <= round_next;
      load      <= load_next;
      out_valid <= out_valid_next;
      if (init_en) init_block <= init_xor;
      if (out_en)  out_block  <= final_xor;
    end
  end

endmodule

// File: tb/tb_aes256_round_seq.sv
// Self-checking bench for aes256_round_seq. Provides the external key
// schedule and round datapath, and checks the sequencer every cycle against
// a cycle-count model whose ciphertexts come from a plain AES-256 encryptor.
module tb_aes256_round_seq;

  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic         in_ready, load, wr_en, out_valid;
  logic [127:0] rk, init_block, out_block;
  logic [127:0] state_q = '0;
  logic [3:0]   rk_idx, round;

  logic [7:0]   sbox [256];
  logic [127:0] rkey [15];

  int n_cmp = 0;
  int n_bad = 0;

  aes256_round_seq dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .rk         (rk),
    .rk_idx     (rk_idx),
    .init_block (init_block),
    .load       (load),
    .wr_en      (wr_en),
    .round      (round),
    .state_q    (state_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(w+4*c) -: 8] = sbox[gb(s, w + 4*((c+w) % 4))];
    return r;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      r[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  task automatic set_key(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rkey[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rkey[0];
    for (int r = 1; r < 14; r++) s = mix(sub_shift(s)) ^ rkey[r];
    return sub_shift(s) ^ rkey[14];
  endfunction

  // ---------------- external key schedule and round datapath ----------------
  assign rk = (rk_idx <= 4'd14) ? rkey[rk_idx] : '0;

  always @(posedge clk) begin
    if (wr_en) begin
      if (round == 4'd13) state_q <= sub_shift(load ? init_block : state_q);
      else                state_q <= mix(sub_shift(load ? init_block : state_q)) ^ rk;
    end
  end

  // ---------------- behavioural model and per-cycle compare ----------------
  // m_t: -1 idle, otherwise cycles elapsed since the accepting edge
  // (0..13 rounds, 14 final key add, 15 ciphertext presented).
  int           m_t  = -1;
  logic [127:0] m_ib = '0;
  logic [127:0] m_ob = '0;
  logic [127:0] m_ct = '0;
  int           cyc  = 0;
  int           acc_cyc [$];

  always begin
    @(posedge clk);
    cyc++;
    if (!resetn) begin
      m_t = -1; m_ib = '0; m_ob = '0;
    end else if (m_t < 0) begin
      if (in_valid) begin
        m_t  = 0;
        m_ib = in_block ^ rkey[0];
        m_ct = aes_ref(in_block);
        acc_cyc.push_back(cyc);
      end
    end else if (m_t == 14) begin
      m_t  = 15;
      m_ob = m_ct;
    end else if (m_t == 15) begin
      if (out_ready) m_t = -1;
    end else begin
      m_t++;
    end
    #1;
    check("in_ready",   in_ready,   m_t < 0);
    check("wr_en",      wr_en,      m_t >= 0 && m_t <= 13);
    check("load",       load,       m_t == 0);
    check("out_valid",  out_valid,  m_t == 15);
    check("out_block",  out_block,  m_ob);
    check("init_block", init_block, m_ib);
    if (m_t >= 0 && m_t <= 14) check("round", round, (m_t == 14) ? 13 : m_t);
    if (m_t < 0)              check("rk_idx", rk_idx, 0);
    else if (m_t <= 13)       check("rk_idx", rk_idx, m_t + 1);
    else if (m_t == 14)       check("rk_idx", rk_idx, 14);
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (in_valid && in_ready && resetn) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_fips();
    bit ok;
    int nw, nl, lk, lat;
    @(negedge clk);
    in_block = PT; in_valid = 1'b1; out_ready = 1'b0;
    wait_accept(ok);
    check("fips_accept", ok, 1);
    nw = 0; nl = 0; lk = -1; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      if (wr_en) nw++;
      if (load) begin nl++; lk = k; end
      if (out_valid) begin lat = k; break; end
    end
    check("wr_en_cycles", nw, 14);
    check("load_pulses",  nl, 1);
    check("load_edge",    lk, 1);
    check("latency",      lat, 16);
    check("fips_ct",      out_block, CT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 1) == 1);
      in_block = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_block", out_block, CT);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("post_hs_ready", in_ready, 1);
    check("post_hs_valid", out_valid, 0);
  endtask

  initial begin
    bit found;
    build_sbox();
    set_key(KEY);
    check("sbox_00", sbox[8'h00], 8'h63);
    check("sbox_53", sbox[8'h53], 8'hed);
    check("model_fips", aes_ref(PT), CT);

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("idle_ready", in_ready, 1);
    check("idle_wr_en", wr_en, 0);
    check("idle_valid", out_valid, 0);
    check("idle_block", out_block, 0);

    run_fips();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    out_ready = 1'b0;

    // reset in the middle of a block
    @(negedge clk);
    in_block = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (wr_en && round == 4'd7) begin found = 1'b1; break; end
    end
    check("reached_round7", found, 1);
    resetn = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_load",  load, 0);
    check("rst_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_round", round, 0);
    check("rst_init",  init_block, 0);
    check("rst_out",   out_block, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_wr_en", wr_en, 0);
    run_fips();

    // back-to-back blocks
    @(negedge clk);
    acc_cyc.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 75; i++) begin
      in_block = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("b2b_count", acc_cyc.size() >= 4, 1);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
